// File: rtl/ascon_serial_loader.sv
// ascon_serial_loader: collects a key/nonce/AD/data message as 32-bit words and streams it bit-serially into the Ascon core.
// Optional WAIT watchdog enabled by defining ASCON_LOADER_TIMEOUT_EN.
`default_nettype none

module ascon_serial_loader #(
    parameter int K            = 128,
    parameter int L            = 40,
    parameter int Y            = 104,
    parameter int START_CYCLES = 4,
    parameter int TIMEOUT      = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_decrypt,
    input  logic        ascon_readyxSO,
    output logic        core_rst,
    output logic        keyxSI,
    output logic        noncexSI,
    output logic        associated_dataxSI,
    output logic        output_dataxSI,
    output logic        ascon_startxSI,
    output logic        decrypt,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int c_N       = 128;
    localparam int c_KW      = (K + 31) / 32;
    localparam int c_NW      = 4;
    localparam int c_AW      = (L + 31) / 32;
    localparam int c_DW      = (Y + 31) / 32;
    localparam int c_TOTAL   = c_KW + c_NW + c_AW + c_DW;
    localparam int c_MAX_KN  = (K > c_N) ? K : c_N;
    localparam int c_MAX_LY  = (L > Y) ? L : Y;
    localparam int c_MAX     = (c_MAX_KN > c_MAX_LY) ? c_MAX_KN : c_MAX_LY;
    localparam int c_LIM_A   = (c_MAX > START_CYCLES) ? c_MAX : START_CYCLES;
    localparam int c_LIM     = (c_LIM_A > TIMEOUT) ? c_LIM_A : TIMEOUT;
    localparam int c_CW      = $clog2(c_LIM + 1);
    localparam int c_WCW     = $clog2(c_TOTAL + 1);
    localparam int c_KIW     = (K > 1) ? $clog2(K) : 1;
    localparam int c_NIW     = $clog2(c_N);
    localparam int c_LIW     = (L > 1) ? $clog2(L) : 1;
    localparam int c_YIW     = (Y > 1) ? $clog2(Y) : 1;

    typedef enum logic [2:0] {
        S_LOAD     = 3'd0,
        S_CORE_RST = 3'd1,
        S_SHIFT    = 3'd2,
        S_START    = 3'd3,
        S_WAIT     = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [c_CW-1:0]  r_cnt;
    logic [c_CW-1:0]  w_cnt_next;
    logic [c_WCW-1:0] r_wcnt;
    logic [K-1:0]     r_key;
    logic [c_N-1:0]   r_nonce;
    logic [L-1:0]     r_ad;
    logic [Y-1:0]     r_data;
    logic [K-1:0]     w_key_next;
    logic [c_N-1:0]   w_nonce_next;
    logic [L-1:0]     w_ad_next;
    logic [Y-1:0]     w_data_next;
    logic             w_accept;
    logic             w_first;
    logic             w_timeout;
    logic             w_shift_next;
    logic [c_CW-1:0]  w_bit_idx;
    logic [c_KIW-1:0] w_kidx;
    logic [c_NIW-1:0] w_nidx;
    logic [c_LIW-1:0] w_lidx;
    logic [c_YIW-1:0] w_yidx;

    assign in_ready = (r_state == S_LOAD);
    assign busy     = (r_state != S_LOAD);
    assign w_accept = in_valid && (r_state == S_LOAD);
    assign w_first  = w_accept && (r_wcnt == '0);

    // Each new word enters at the bottom; only the low field-width bits survive.
    generate
        if (K > 32) begin : g_key_wide
            assign w_key_next = {r_key[K-33:0], in_data};
        end else begin : g_key_narrow
            assign w_key_next = in_data[K-1:0];
        end
        if (L > 32) begin : g_ad_wide
            assign w_ad_next = {r_ad[L-33:0], in_data};
        end else begin : g_ad_narrow
            assign w_ad_next = in_data[L-1:0];
        end
        if (Y > 32) begin : g_data_wide
            assign w_data_next = {r_data[Y-33:0], in_data};
        end else begin : g_data_narrow
            assign w_data_next = in_data[Y-1:0];
        end
    endgenerate
    assign w_nonce_next = {r_nonce[c_N-33:0], in_data};

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_timeout    = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (w_accept && (r_wcnt == c_WCW'(c_TOTAL - 1))) begin
                    w_state_next = S_CORE_RST;
                    w_cnt_next   = '0;
                end
            end
            S_CORE_RST: begin
                if (r_cnt == c_CW'(1)) begin
                    w_state_next = S_SHIFT;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_cnt == c_CW'(c_MAX - 1)) begin
                    w_state_next = S_START;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_START: begin
                if (r_cnt == c_CW'(START_CYCLES - 1)) begin
                    w_state_next = S_WAIT;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (ascon_readyxSO) begin
                    w_state_next = S_LOAD;
                    w_cnt_next   = '0;
                end
`ifdef ASCON_LOADER_TIMEOUT_EN
                else if (r_cnt == c_CW'(TIMEOUT - 1)) begin
                    w_state_next = S_LOAD;
                    w_cnt_next   = '0;
                    w_timeout    = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
`endif
            end
            default: begin
                w_state_next = S_LOAD;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt  <= '0;
            r_key   <= '0;
            r_nonce <= '0;
            r_ad    <= '0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_wcnt <= r_wcnt + 1'b1;
            if (r_wcnt < c_WCW'(c_KW))
                r_key <= w_key_next;
            else if (r_wcnt < c_WCW'(c_KW + c_NW))
                r_nonce <= w_nonce_next;
            else if (r_wcnt < c_WCW'(c_KW + c_NW + c_AW))
                r_ad <= w_ad_next;
            else
                r_data <= w_data_next;
        end else if ((r_state == S_WAIT) && (w_state_next == S_LOAD)) begin
            r_wcnt <= '0;
        end
    end

    // Index of the bit to present after this edge; outputs are registered one cycle ahead.
    assign w_shift_next = (w_state_next == S_SHIFT);
    assign w_bit_idx    = (r_state == S_SHIFT) ? r_cnt + 1'b1 : '0;
    assign w_kidx       = c_KIW'(K - 1)   - w_bit_idx[c_KIW-1:0];
    assign w_nidx       = c_NIW'(c_N - 1) - w_bit_idx[c_NIW-1:0];
    assign w_lidx       = c_LIW'(L - 1)   - w_bit_idx[c_LIW-1:0];
    assign w_yidx       = c_YIW'(Y - 1)   - w_bit_idx[c_YIW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_rst           <= 1'b0;
            keyxSI             <= 1'b0;
            noncexSI           <= 1'b0;
            associated_dataxSI <= 1'b0;
            output_dataxSI     <= 1'b0;
            ascon_startxSI     <= 1'b0;
            decrypt            <= 1'b0;
            done               <= 1'b0;
        end else begin
            core_rst           <= (w_state_next == S_CORE_RST);
            ascon_startxSI     <= (w_state_next == S_START);
            keyxSI             <= w_shift_next && (w_bit_idx < c_CW'(K))   && r_key[w_kidx];
            noncexSI           <= w_shift_next && (w_bit_idx < c_CW'(c_N)) && r_nonce[w_nidx];
            associated_dataxSI <= w_shift_next && (w_bit_idx < c_CW'(L))   && r_ad[w_lidx];
            output_dataxSI     <= w_shift_next && (w_bit_idx < c_CW'(Y))   && r_data[w_yidx];
            done               <= (r_state == S_WAIT) && ascon_readyxSO;
            if (w_first)
                decrypt <= in_decrypt;
        end
    end

`ifdef ASCON_LOADER_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (w_timeout)
            err <= 1'b1;
        else if (w_first)
            err <= 1'b0;
    end
`else
    assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ascon_serial_loader.sv
// tb_ascon_serial_loader: scoreboard bench for ascon_serial_loader with default field widths.
`default_nettype none

module tb_ascon_serial_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_decrypt = 1'b0;
    logic        ascon_readyxSO = 1'b0;
    logic        in_ready, core_rst, keyxSI, noncexSI, associated_dataxSI, output_dataxSI;
    logic        ascon_startxSI, decrypt, busy, done, err;

    ascon_serial_loader #(
        .K(128), .L(40), .Y(104), .START_CYCLES(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_decrypt(in_decrypt), .ascon_readyxSO(ascon_readyxSO), .core_rst(core_rst),
        .keyxSI(keyxSI), .noncexSI(noncexSI), .associated_dataxSI(associated_dataxSI),
        .output_dataxSI(output_dataxSI), .ascon_startxSI(ascon_startxSI), .decrypt(decrypt),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] key;
        logic [127:0] nonce;
        logic [127:0] ad;
        logic [127:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] msg[14];
    int          vectors = 0;
    int          miscompares = 0;
    int          acc_cnt;
    logic [127:0] cap_key, cap_nonce, cap_ad, cap_data;
    int          cap_rst, cap_start, cap_first, cap_dec, cap_busy_low, cap_done_early, cap_wait_bad;
    logic        cap_done_after, cap_rdy_after, cap_done_next;
    logic [10:0] outs;
    localparam logic [10:0] RST_OUTS = 11'b100_0000_0000;

    assign outs = {in_ready, busy, core_rst, keyxSI, noncexSI, associated_dataxSI,
                   output_dataxSI, ascon_startxSI, decrypt, done, err};

    task automatic load_plan_words();
        msg = '{32'h6d4f8bbf, 32'h60ec05a0, 32'h7b201d4e, 32'h5b2119ac,
                32'h05885e60, 32'h6e1271b8, 32'hd47a74c7, 32'hb297a318,
                32'h00000041, 32'h53434f4e,
                32'h00000061, 32'h73636f6e, 32'h2d756e69, 32'h63617373};
    endtask

    task automatic load_random_words();
        for (int i = 0; i < 14; i++) msg[i] = $urandom;
    endtask

    // Push the expected serial streams, then present words until 14 are accepted.
    task automatic feed(input bit dec, input bit gaps);
        exp_t x;
        int   guard;
        bit   acc;
        x.key   = {msg[0], msg[1], msg[2], msg[3]};
        x.nonce = {msg[4], msg[5], msg[6], msg[7]};
        x.ad    = {msg[8][7:0], msg[9], 88'h0};
        x.data  = {msg[10][7:0], msg[11], msg[12], msg[13], 24'h0};
        sb.push_back(x);
        acc_cnt = 0;
        guard   = 0;
        while (acc_cnt < 14 && guard < 100) begin
            @(negedge clk);
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                in_data  = $urandom;
            end else begin
                in_valid   = 1'b1;
                in_data    = msg[acc_cnt];
                in_decrypt = (acc_cnt == 0) ? dec : 1'b0;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) acc_cnt++;
            guard++;
        end
    endtask

    // Observe cycles after E0..E133 (CORE_RST, SHIFT, START).
    task automatic observe(input bit early, input bit junk);
        cap_key = '0; cap_nonce = '0; cap_ad = '0; cap_data = '0;
        cap_rst = 0; cap_start = 0; cap_first = -1; cap_dec = 0; cap_busy_low = 0; cap_done_early = 0;
        for (int k = 0; k < 134; k++) begin
            @(negedge clk);
            in_valid       = junk;
            in_data        = $urandom;
            in_decrypt     = 1'($urandom);
            ascon_readyxSO = early && (k < 133);
            if (core_rst) cap_rst++;
            if (ascon_startxSI) begin
                if (cap_start == 0) cap_first = k;
                cap_start++;
            end
            if (k >= 2 && k < 130) begin
                cap_key[129-k]   = keyxSI;
                cap_nonce[129-k] = noncexSI;
                cap_ad[129-k]    = associated_dataxSI;
                cap_data[129-k]  = output_dataxSI;
            end
            if (decrypt) cap_dec++;
            if (!busy) cap_busy_low++;
            if (done) cap_done_early++;
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_wait(input int delay);
        cap_wait_bad = 0;
        for (int j = 0; j <= delay; j++) begin
            @(negedge clk);
            if (!busy || done) cap_wait_bad++;
            if (j == delay) ascon_readyxSO = 1'b1;
        end
        @(negedge clk);
        cap_done_after = done;
        cap_rdy_after  = in_ready;
        ascon_readyxSO = 1'b0;
        @(negedge clk);
        cap_done_next = done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (outs !== RST_OUTS) begin
            miscompares++;
            $display("FAIL reset_hold: got %b expected %b", outs, RST_OUTS);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (outs !== RST_OUTS) begin
            miscompares++;
            $display("FAIL reset_release: got %b expected %b", outs, RST_OUTS);
        end
    endtask

    task automatic test_basic();
        load_plan_words();
        feed(1'b0, 1'b0);
        observe(1'b0, 1'b0);
        finish_wait(3);
        e = sb.pop_front();
        vectors++;
        if (cap_key !== 128'h6d4f8bbf60ec05a07b201d4e5b2119ac) begin
            miscompares++; $display("FAIL basic_key_literal: got %h", cap_key);
        end
        vectors++;
        if (cap_key !== e.key) begin
            miscompares++; $display("FAIL basic_key: got %h expected %h", cap_key, e.key);
        end
        vectors++;
        if (cap_nonce !== e.nonce) begin
            miscompares++; $display("FAIL basic_nonce: got %h expected %h", cap_nonce, e.nonce);
        end
        vectors++;
        if (cap_ad !== {40'h4153434f4e, 88'h0}) begin
            miscompares++; $display("FAIL basic_ad: got %h expected %h", cap_ad, {40'h4153434f4e, 88'h0});
        end
        vectors++;
        if (cap_data !== {104'h6173636f6e2d756e6963617373, 24'h0}) begin
            miscompares++; $display("FAIL basic_data: got %h expected %h", cap_data, e.data);
        end
        vectors++;
        if (cap_rst !== 2) begin
            miscompares++; $display("FAIL basic_core_rst_len: got %0d expected 2", cap_rst);
        end
        vectors++;
        if (cap_start !== 4 || cap_first !== 130) begin
            miscompares++; $display("FAIL basic_start: got len %0d at %0d expected 4 at 130", cap_start, cap_first);
        end
        vectors++;
        if (cap_dec !== 0 || cap_busy_low !== 0 || cap_done_early !== 0) begin
            miscompares++;
            $display("FAIL basic_run_flags: got dec %0d busylow %0d done %0d expected 0 0 0", cap_dec, cap_busy_low, cap_done_early);
        end
        vectors++;
        if ({cap_wait_bad != 0, cap_done_after, cap_rdy_after, cap_done_next} !== 4'b0110) begin
            miscompares++;
            $display("FAIL basic_done: got bad %0d done %b rdy %b next %b expected 0 1 1 0", cap_wait_bad, cap_done_after, cap_rdy_after, cap_done_next);
        end
    endtask

    task automatic test_decrypt();
        load_plan_words();
        feed(1'b1, 1'b0);
        observe(1'b0, 1'b1);
        finish_wait(1);
        e = sb.pop_front();
        vectors++;
        if (cap_dec !== 134 || decrypt !== 1'b1) begin
            miscompares++; $display("FAIL decrypt_hold: got %0d cycles expected 134", cap_dec);
        end
        vectors++;
        if ({cap_key, cap_nonce} !== {e.key, e.nonce} || {cap_ad, cap_data} !== {e.ad, e.data}) begin
            miscompares++; $display("FAIL decrypt_streams_with_junk: got key %h data %h expected %h %h", cap_key, cap_data, e.key, e.data);
        end
        vectors++;
        if (cap_rst !== 2 || cap_start !== 4 || cap_first !== 130) begin
            miscompares++; $display("FAIL decrypt_timing: got rst %0d start %0d at %0d", cap_rst, cap_start, cap_first);
        end
    endtask

    task automatic test_early_ready();
        load_random_words();
        feed(1'b0, 1'b0);
        observe(1'b1, 1'b0);
        finish_wait(10);
        e = sb.pop_front();
        vectors++;
        if (cap_busy_low !== 0 || cap_done_early !== 0 || cap_wait_bad !== 0) begin
            miscompares++;
            $display("FAIL early_ready_exit: got busylow %0d done %0d waitbad %0d expected 0", cap_busy_low, cap_done_early, cap_wait_bad);
        end
        vectors++;
        if ({cap_done_after, cap_rdy_after, cap_done_next} !== 3'b110) begin
            miscompares++; $display("FAIL early_ready_done: got %b%b%b expected 110", cap_done_after, cap_rdy_after, cap_done_next);
        end
        vectors++;
        if (cap_data !== e.data || cap_key !== e.key) begin
            miscompares++; $display("FAIL early_ready_streams: got %h expected %h", cap_data, e.data);
        end
    endtask

    task automatic test_reset_mid();
        load_random_words();
        feed(1'b1, 1'b0);
        e = sb.pop_back();
        for (int k = 0; k <= 52; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        vectors++;
        if (busy !== 1'b1 || decrypt !== 1'b1) begin
            miscompares++; $display("FAIL mid_pre_reset: got busy %b decrypt %b expected 1 1", busy, decrypt);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (outs !== RST_OUTS) begin
            miscompares++; $display("FAIL mid_reset: got %b expected %b", outs, RST_OUTS);
        end
        @(negedge clk);
        rst = 1'b0;
        load_random_words();
        feed(1'b0, 1'b0);
        observe(1'b0, 1'b0);
        finish_wait(2);
        e = sb.pop_front();
        vectors++;
        if ({cap_key, cap_nonce, cap_ad, cap_data} !== {e.key, e.nonce, e.ad, e.data} || !cap_done_after) begin
            miscompares++; $display("FAIL mid_reload: got key %h ad %h expected %h %h", cap_key, cap_ad, e.key, e.ad);
        end
    endtask

    task automatic test_gaps();
        load_random_words();
        feed(1'b0, 1'b1);
        vectors++;
        if (acc_cnt !== 14) begin
            miscompares++; $display("FAIL gaps_accepts: got %0d expected 14", acc_cnt);
        end
        observe(1'b0, 1'b1);
        finish_wait(0);
        e = sb.pop_front();
        vectors++;
        if ({cap_key, cap_nonce, cap_ad, cap_data} !== {e.key, e.nonce, e.ad, e.data}) begin
            miscompares++; $display("FAIL gaps_streams: got nonce %h data %h expected %h %h", cap_nonce, cap_data, e.nonce, e.data);
        end
    endtask

`ifdef ASCON_LOADER_TIMEOUT_EN
    task automatic test_timeout();
        int early_exit;
        load_random_words();
        feed(1'b0, 1'b0);
        observe(1'b0, 1'b0);
        e = sb.pop_front();
        early_exit = 0;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (!busy || err) early_exit++;
        end
        @(negedge clk);
        vectors++;
        if (early_exit !== 0 || {busy, err, done, in_ready} !== 4'b0101) begin
            miscompares++;
            $display("FAIL timeout_err: got early %0d busy %b err %b done %b rdy %b expected 0 0 1 0 1", early_exit, busy, err, done, in_ready);
        end
        load_random_words();
        feed(1'b0, 1'b0);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++; $display("FAIL timeout_err_clear: got %b expected 0", err);
        end
        observe(1'b0, 1'b0);
        finish_wait(0);
        e = sb.pop_front();
    endtask
`else
    task automatic test_no_timeout();
        load_random_words();
        feed(1'b0, 1'b0);
        observe(1'b0, 1'b0);
        finish_wait(40);
        e = sb.pop_front();
        vectors++;
        if (cap_wait_bad !== 0 || err !== 1'b0 || !cap_done_after) begin
            miscompares++; $display("FAIL no_timeout_hold: got waitbad %0d err %b done %b", cap_wait_bad, err, cap_done_after);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_decrypt();
        test_early_ready();
        test_reset_mid();
        test_gaps();
`ifdef ASCON_LOADER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/ascon_serial_loader.md
# ascon_serial_loader

Upstream feeder for the Ascon serial core. Accepts a message as a stream of 32-bit words over a valid/ready handshake: key, nonce, associated data, then plaintext/ciphertext. It resets the core, shifts all four fields out MSB-first on the core's bit-serial inputs, pulses start, and waits for the core's ready flag before accepting the next message.

## Interface
Parameters:
- `K`, 128: key width in bits; the nonce is fixed at 128 bits.
- `L`, 40: associated-data width in bits.
- `Y`, 104: data (PT/CT) width in bits.
- `START_CYCLES`, 4: length of the start pulse in cycles.
- `TIMEOUT`, 4096: WAIT watchdog limit in cycles. Used only with the configuration macro.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_data` in 32: input word.
- `in_valid` in 1: word valid.
- `in_ready` out 1: loader accepts words.
- `in_decrypt` in 1: mode flag, sampled with the first word of a message.
- `ascon_readyxSO` in 1: core-done flag from the core.
- `core_rst` out 1: reset to the core.
- `keyxSI`, `noncexSI`, `associated_dataxSI`, `output_dataxSI` out 1 each: serial field bits.
- `ascon_startxSI` out 1: core start.
- `decrypt` out 1: mode to the core.
- `busy` out 1: high in any state other than LOAD.
- `done` out 1: one-cycle pulse when the core reports ready.
- `err` out 1: watchdog error.

## Operation
- Field words, in this order: `ceil(K/32)` key words, 4 nonce words, `ceil(L/32)` AD words, `ceil(Y/32)` data words. With defaults this is 4+4+2+4 = 14 words.
- Word layout within a field:
  - The first word of each field is the most significant.
  - The field value is the low field-width bits of the word concatenation; the upper pad bits are ignored.
- States and transitions:
  - LOAD: `in_ready`=1. A word is accepted at a posedge with `in_valid`&&`in_ready`. The word counter increments on each acceptance. Acceptance of the last word moves to CORE_RST.
  - CORE_RST: 2 cycles, `core_rst`=1, then SHIFT.
  - SHIFT: `MAX = max(K,128,L,Y)` cycles; bit counter `i` runs 0..MAX-1.
    - `keyxSI` = key[K-1-i] while i<K, else 0. The other three lines follow the same rule with their own widths.
    - After MAX cycles, go to START.
  - START: `ascon_startxSI`=1 for `START_CYCLES` cycles, then WAIT.
  - WAIT: `ascon_readyxSO` sampled 1 at a posedge → LOAD. `done` pulses for one cycle and the word counter clears.
- `ascon_readyxSO` is ignored in every state except WAIT.
- `decrypt` loads from `in_decrypt` when the first word of a message is accepted, and holds until the next first-word acceptance.
- `in_valid` outside LOAD is ignored; no word is consumed.
- Field registers hold their contents after SHIFT; they are overwritten only by new words.

## Timing
- All outputs are registered except `in_ready` and `busy`, which decode state.
- Reset values while `rst` is high and until the first edge after its release:
  - state=LOAD, all counters 0, field registers 0.
  - `in_ready`=1, `busy`=0.
  - `core_rst`=0, all serial lines 0, `ascon_startxSI`=0, `decrypt`=0, `done`=0, `err`=0.
- Cycle numbering, with the last word accepted at edge E0:
  - `core_rst`=1 after E0 and after E1.
  - Bit i is presented after E(2+i).
  - `ascon_startxSI`=1 after E(2+MAX) through E(1+MAX+START_CYCLES).
  - WAIT is entered at E(2+MAX+START_CYCLES). With defaults that is E134.
- If ready is sampled at WAIT edge Ew, `done`=1 and `in_ready`=1 in the cycle after Ew. A new first word can be accepted at Ew+1.
- Reset mid-operation (any state) aborts immediately to reset values. A partially loaded message is discarded.
- Back-to-back words: one word per cycle is sustained in LOAD.

## Configuration
- `ASCON_LOADER_TIMEOUT_EN` defined:
  - A WAIT cycle counter starts at 0 on entry.
  - If `ascon_readyxSO` is not seen within `TIMEOUT` cycles, go to LOAD and set `err`=1 (sticky). `done` does not pulse.
  - `err` clears on the next first-word acceptance or on reset.
- Undefined: no counter, WAIT is held indefinitely, and `err` is tied to 0.

## Test plan
- Reset, then feed 14 words:
  - Key: 0x6d4f8bbf, 0x60ec05a0, 0x7b201d4e, 0x5b2119ac.
  - Nonce: 0x05885e60, 0x6e1271b8, 0xd47a74c7, 0xb297a318.
  - AD: 0x00000041, 0x53434f4e.
  - Data: 0x00000061, 0x73636f6e, 0x2d756e69, 0x63617373.
  - Required: captured 128-bit `keyxSI` stream = 0x6d4f8bbf60ec05a07b201d4e5b2119ac. First 40 AD bits = 0x4153434f4e, then 0. First 104 data bits = 0x6173636f6e2d756e6963617373.
- Same load with `in_decrypt`=1 on word 0 and 0 on the rest → `decrypt`=1 through the whole run. `core_rst` is high exactly 2 cycles. Start is high exactly 4 cycles beginning 130 cycles after the last-word edge.
- Hold `ascon_readyxSO`=1 during SHIFT/START, then drop it → no exit before WAIT. Raise it 10 cycles into WAIT → `done` pulses once, `in_ready`=1 the next cycle.
- Assert `rst` at SHIFT bit 50 → all outputs return to reset values at once. A fresh 14-word load then completes normally.
- Drive `in_valid` toggling 1/0 with random gaps → exactly 14 acceptances. Words presented while `in_ready`=0 are not consumed.
- With `ASCON_LOADER_TIMEOUT_EN` and `TIMEOUT`=16, never raise ready → after 16 WAIT cycles, `err`=1, `done`=0, state=LOAD. The next first word clears `err`.
